// File: rtl/alu_seq_ctrl.sv
// Purpose: sequences register-to-register commands through an external 8-bit ALU (read, execute, write back, respond).
// Latency: response valid 2 cycles after command accept; minimum issue interval 3 cycles.
// Backpressure: cmd_ready only in IDLE; a response is held in RESP until resp_ready is seen.
module alu_seq_ctrl #(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_rs,
  input  logic [$clog2(NREG)-1:0] cmd_rt,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DW-1:0]           resp_data,
  output logic                    resp_err,
  output logic                    flag_c,
  output logic                    flag_z,
  input  logic                    ld_en,
  input  logic [$clog2(NREG)-1:0] ld_addr,
  input  logic [DW-1:0]           ld_data,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  output logic [DW-1:0]           rd_data,
  output logic [3:0]              alu_ctrl,
  output logic [DW-1:0]           alu_x,
  output logic [DW-1:0]           alu_y,
  input  logic [DW-1:0]           alu_out,
  input  logic                    alu_carry
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            cmd_acc;
  logic            resp_done;
  logic            in_exec;
  logic            op_reserved;
  logic            op_arith;
  logic            wb_en;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   rf [NREG];

  // Ops 13..15 are reserved; only add/sub (0,1) produce a meaningful carry.
  assign op_reserved = (alu_ctrl >= 4'd13);
  assign op_arith    = (alu_ctrl < 4'd2);
  assign wb_en       = in_exec && !op_reserved;
  assign rd_data     = rf[rd_addr];

  // State register; reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    cmd_acc    = 1'b0;
    resp_done  = 1'b0;
    in_exec    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_acc    = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        in_exec    = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          resp_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on accept, result/flag capture on EXEC exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctrl  <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      rd_q      <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      if (cmd_acc) begin
        // Pre-edge rf contents: a same-edge load is not seen here.
        alu_ctrl <= cmd_op;
        alu_x    <= rf[cmd_rs];
        alu_y    <= rf[cmd_rt];
        rd_q     <= cmd_rd;
      end
      if (in_exec) begin
        if (op_reserved) begin
          // Flags are left untouched for reserved ops.
          resp_data <= '0;
          resp_err  <= 1'b1;
        end else begin
          resp_data <= alu_out;
          resp_err  <= 1'b0;
          flag_c    <= op_arith ? alu_carry : 1'b0;
          flag_z    <= (alu_out == '0);
        end
      end else if (resp_done) begin
        resp_err <= 1'b0;
      end
    end
  end

  // Register file: direct load first, so a same-address writeback overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        rf[ld_addr] <= ld_data;
      end
      if (wb_en) begin
        rf[rd_q] <= alu_out;
      end
    end
  end

endmodule
